ps2_keycode_decoder: RTL and testbench

- Receive-side PS/2 keyboard interface. Produces the `keycode` and `press` signals consumed by the player motion/animation blocks.
- Deserialises 11-bit device-to-host frames from the keyboard and tracks E0 (extended) and F0 (break) prefixes.
- Presents a held make/break key state on the system clock (50 MHz) domain.

---
 rtl/ps2_keycode_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: 11-bit frame deserialiser with E0/F0 prefix tracking.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_keycode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] keycode,
  output logic       press,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_PROCESS
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_MAX = '1;
  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  logic clk_meta_q, clk_sync_q, clk_hist_q;
  logic dat_meta_q, dat_sync_q;

  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic brk_q, brk_d;
  logic ext_q, ext_d;

  logic [7:0] keycode_q, keycode_d;
  logic press_q, press_d;
  logic extended_q, extended_d;
  logic key_valid_q, key_valid_d;
  logic frame_err_q, frame_err_d;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  logic par_ok;
  assign par_ok = ^{shift_q, par_q};
`endif

  logic fall;
  logic timeout;

  assign fall    = clk_hist_q & ~clk_sync_q;
  assign timeout = (state_q != S_IDLE) && !fall && (tmo_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    keycode_d   = keycode_q;
    press_d     = press_q;
    extended_d  = extended_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif

    if (state_q == S_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TO_MAX) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (timeout) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
      brk_d       = 1'b0;
      ext_d       = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (fall && !dat_sync_q) begin
            state_d   = S_START;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        S_START: begin
          if (fall) begin
            shift_d   = {dat_sync_q, shift_q[7:1]};
            bit_cnt_d = 3'd1;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (fall) begin
            shift_d   = {dat_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_PARITY;
            end
          end
        end
        S_PARITY: begin
          if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
            par_d   = dat_sync_q;
`endif
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (fall) begin
            if (!dat_sync_q) begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
`ifdef PS2_PARITY_CHECK_EN
            end else if (!par_ok) begin
              frame_err_d = 1'b1;
              state_d     = S_IDLE;
`endif
            end else begin
              state_d = S_PROCESS;
            end
          end
        end
        S_PROCESS: begin
          state_d = S_IDLE;
          if (shift_q == CODE_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == CODE_BRK) begin
            brk_d = 1'b1;
          end else begin
            if (!brk_q) begin
              keycode_d   = shift_q;
              extended_d  = ext_q;
              press_d     = 1'b1;
              key_valid_d = 1'b1;
            end else if ({ext_q, shift_q} == {extended_q, keycode_q}) begin
              press_d     = 1'b0;
              key_valid_d = 1'b1;
            end
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Synchroniser flops reset high to match an idle bus.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_hist_q  <= 1'b1;
      dat_meta_q  <= 1'b1;
      dat_sync_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      keycode_q   <= '0;
      press_q     <= 1'b0;
      extended_q  <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      clk_hist_q  <= clk_sync_q;
      dat_meta_q  <= ps2_dat;
      dat_sync_q  <= dat_meta_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      keycode_q   <= keycode_d;
      press_q     <= press_d;
      extended_q  <= extended_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign keycode   = keycode_q;
  assign press     = press_q;
  assign extended  = extended_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed bench for ps2_keycode_decoder: make/break, prefixes,
// timeout, stop/parity errors and async reset.
module tb_ps2_keycode_decoder;

  localparam int TO = 200;

  logic       Clk;
  logic       Reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] keycode;
  logic       press;
  logic       extended;
  logic       key_valid;
  logic       frame_err;

  int n_vec;
  int n_err;
  int kv_cnt;
  int fe_cnt;
  int kv0;
  int fe0;

  ps2_keycode_decoder #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W(16)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .keycode(keycode),
    .press(press),
    .extended(extended),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    kv0 = kv_cnt;
    fe0 = fe_cnt;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = fr[i];
      repeat (5) @(negedge Clk);
      ps2_clk = 1'b0;
      repeat (10) @(negedge Clk);
      ps2_clk = 1'b1;
      repeat (5) @(negedge Clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par,
                      input logic bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bits({~bad_stop, p, b, 1'b0}, 11);
    ps2_dat = 1'b1;
    repeat (12) @(negedge Clk);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    kv_cnt  = 0;
    fe_cnt  = 0;
    Reset   = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(negedge Clk);
    check("rst_out", {keycode, press, extended, key_valid, frame_err},
          32'h0);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);

    // make 1C
    snap();
    key(8'h1C);
    check("t1_code", keycode, 8'h1C);
    check("t1_press", press, 1);
    check("t1_ext", extended, 0);
    check("t1_kv", kv_cnt - kv0, 1);
    check("t1_fe", fe_cnt - fe0, 0);

    // break 1C
    snap();
    key(8'hF0);
    check("t2_f0_kv", kv_cnt - kv0, 0);
    key(8'h1C);
    check("t2_press", press, 0);
    check("t2_code", keycode, 8'h1C);
    check("t2_kv", kv_cnt - kv0, 1);

    // last key wins, break of non-held key ignored
    key(8'h1C);
    key(8'h23);
    check("t3_code", keycode, 8'h23);
    check("t3_press", press, 1);
    snap();
    key(8'hF0);
    key(8'h1C);
    check("t3_brk_code", keycode, 8'h23);
    check("t3_brk_press", press, 1);
    check("t3_brk_kv", kv_cnt - kv0, 0);

    // typematic repeat
    snap();
    key(8'h23);
    key(8'h23);
    check("rep_kv", kv_cnt - kv0, 2);
    check("rep_code", keycode, 8'h23);

    // extended make / break
    key(8'hE0);
    key(8'h74);
    check("t4_code", keycode, 8'h74);
    check("t4_ext", extended, 1);
    check("t4_press", press, 1);
    key(8'hF0);
    key(8'h74);
    check("t4_plain_brk", press, 1);
    key(8'hE0);
    key(8'hF0);
    key(8'h74);
    check("t4_ext_brk", press, 0);
    check("t4_ext_keep", extended, 1);
    check("t4_code_keep", keycode, 8'h74);

    // pending F0 then a timed-out partial frame: brk must clear
    key(8'hF0);
    snap();
    send_bits(11'b000_0011_1000, 5);
    ps2_dat = 1'b1;
    repeat (TO + 30) @(negedge Clk);
    check("t5_fe", fe_cnt - fe0, 1);
    check("t5_kv", kv_cnt - kv0, 0);
    key(8'h1C);
    check("t5_code", keycode, 8'h1C);
    check("t5_press", press, 1);
    check("t5_ext", extended, 0);

    // bad stop bit
    snap();
    send(8'h23, 1'b0, 1'b1);
    check("stop_fe", fe_cnt - fe0, 1);
    check("stop_kv", kv_cnt - kv0, 0);
    check("stop_code", keycode, 8'h1C);

    // parity error on 1C after releasing it
    key(8'hF0);
    key(8'h1C);
    check("t6_pre_press", press, 0);
    snap();
    send(8'h1C, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("t6_fe", fe_cnt - fe0, 1);
    check("t6_press", press, 0);
    check("t6_kv", kv_cnt - kv0, 0);
`else
    check("t6_fe", fe_cnt - fe0, 0);
    check("t6_press", press, 1);
    check("t6_code", keycode, 8'h1C);
`endif

    // reset mid-frame discards the partial frame
    key(8'h23);
    send_bits(11'b000_0011_1000, 4);
    Reset = 1'b0;
    #1;
    check("mid_rst", {keycode, press, extended}, 32'h0);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    key(8'h1C);
    check("post_rst_code", keycode, 8'h1C);
    check("post_rst_press", press, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
